abs_diff_accum: RTL and testbench

- Parametrised, pipelined multi-lane absolute-difference unit with a sum-of-absolute-differences (SAD) accumulator.
- Each beat computes |A−B| per lane on (2*WIDTH+1)-bit operands in signed or unsigned mode, registers the per-lane results, and adds them into a vector-length accumulator.
- Sits between the PE-array result path and the error/metric collection logic.
- Valid/ready handshake on input and output.

---
 rtl/abs_diff_accum_if.sv | 32 +++
 rtl/abs_diff_accum.sv | 128 ++++++++++++
 tb/tb_abs_diff_accum.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/abs_diff_accum_if.sv
// rtl/abs_diff_accum_if.sv - beat/config/result bundle for the SAD unit
interface abs_diff_accum_if #(
  parameter int WIDTH   = 16,
  parameter int LANES   = 4,
  parameter int MAX_LEN = 64
);
  localparam int DW    = 2*WIDTH + 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int ACC_W = DW + $clog2(LANES) + $clog2(MAX_LEN) + 1;

  logic [LEN_W-1:0]    cfg_len;
  logic                cfg_signed;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] in_a;
  logic [LANES*DW-1:0] in_b;
  logic [LANES*DW-1:0] diff_out;
  logic                diff_valid;
  logic [ACC_W-1:0]    sad_out;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output cfg_len, cfg_signed, in_valid, in_a, in_b, out_ready,
    input  in_ready, diff_out, diff_valid, sad_out, out_valid
  );

  modport slave (
    input  cfg_len, cfg_signed, in_valid, in_a, in_b, out_ready,
    output in_ready, diff_out, diff_valid, sad_out, out_valid
  );
endinterface

// File: rtl/abs_diff_accum.sv
// rtl/abs_diff_accum.sv - pipelined multi-lane |A-B| with vector SAD accumulator
module abs_diff_accum #(
  parameter int WIDTH   = 16,
  parameter int LANES   = 4,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int ACC_W   = (2*WIDTH + 1) + $clog2(LANES) + $clog2(MAX_LEN) + 1
) (
  input logic              clk,
  input logic              rst_n,
  abs_diff_accum_if.slave  bus
);
  localparam int DW = 2*WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t              state;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    count;
  logic [LEN_W-1:0]    eff_len;
  logic                sgn_q;
  logic                sgn_eff;
  logic                accept;
  logic [LANES*DW-1:0] diff_next;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    lane_sum;
  logic [DW:0]         ea;
  logic [DW:0]         eb;
  logic [DW:0]         d;

  assign accept  = bus.in_valid && bus.in_ready;
  // The first beat of a vector uses the live mode bit; later beats use the latched one.
  assign sgn_eff = (state == IDLE) ? bus.cfg_signed : sgn_q;

  always_comb begin
    if (bus.cfg_len == '0)
      eff_len = LEN_W'(1);
    else if (bus.cfg_len > LEN_W'(MAX_LEN))
      eff_len = LEN_W'(MAX_LEN);
    else
      eff_len = bus.cfg_len;
  end

  // One extra bit of headroom keeps the difference exact for every operand pair.
  always_comb begin
    diff_next = '0;
    ea = '0;
    eb = '0;
    d  = '0;
    for (int i = 0; i < LANES; i++) begin
      ea = {sgn_eff & bus.in_a[i*DW + DW - 1], bus.in_a[i*DW +: DW]};
      eb = {sgn_eff & bus.in_b[i*DW + DW - 1], bus.in_b[i*DW +: DW]};
      d  = ea - eb;
      diff_next[i*DW +: DW] = d[DW] ? DW'(eb - ea) : d[DW-1:0];
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + ACC_W'(bus.diff_out[i*DW +: DW]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      len_q          <= '0;
      count          <= '0;
      sgn_q          <= 1'b0;
      acc            <= '0;
      bus.in_ready   <= 1'b1;
      bus.diff_out   <= '0;
      bus.diff_valid <= 1'b0;
      bus.sad_out    <= '0;
      bus.out_valid  <= 1'b0;
    end else begin
      bus.diff_valid <= accept;
      if (accept)
        bus.diff_out <= diff_next;

      case (state)
        IDLE: begin
          if (accept) begin
            len_q <= eff_len;
            sgn_q <= bus.cfg_signed;
            acc   <= '0;
            count <= LEN_W'(1);
            if (eff_len == LEN_W'(1)) begin
              state        <= DRAIN;
              bus.in_ready <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (bus.diff_valid)
            acc <= acc + lane_sum;
          if (accept) begin
            count <= count + LEN_W'(1);
            if (count + LEN_W'(1) == len_q) begin
              state        <= DRAIN;
              bus.in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // The last beat's lanes are still in diff_out; fold them in while publishing.
          acc           <= acc + lane_sum;
          bus.sad_out   <= acc + lane_sum;
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_abs_diff_accum.sv
// tb/tb_abs_diff_accum.sv - randomized self-checking bench for abs_diff_accum
module tb_abs_diff_accum;
  localparam int WIDTH   = 16;
  localparam int LANES   = 4;
  localparam int MAX_LEN = 64;
  localparam int DW      = 2*WIDTH + 1;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int ACC_W   = DW + $clog2(LANES) + $clog2(MAX_LEN) + 1;

  typedef logic [LANES*DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  abs_diff_accum_if #(.WIDTH(WIDTH), .LANES(LANES), .MAX_LEN(MAX_LEN)) bus ();

  abs_diff_accum #(.WIDTH(WIDTH), .LANES(LANES), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  vec_t             va [MAX_LEN];
  vec_t             vb [MAX_LEN];
  vec_t             obs_diff [MAX_LEN];
  logic             obs_dv [MAX_LEN];
  int               obs_lat, obs_rdy_bad, obs_early, obs_unstable, obs_hold_rdy, obs_hold_acc;
  logic [ACC_W-1:0] obs_sad;
  logic             obs_rdy_after, obs_ov_after;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint lane_val(logic [DW-1:0] x, bit sgn);
    if (sgn) return longint'($signed(x));
    return longint'(x);
  endfunction

  function automatic longint abs_diff(logic [DW-1:0] a, logic [DW-1:0] b, bit sgn);
    longint la = lane_val(a, sgn);
    longint lb = lane_val(b, sgn);
    return (la >= lb) ? la - lb : lb - la;
  endfunction

  function automatic vec_t model_diff(vec_t a, vec_t b, bit sgn);
    vec_t r = '0;
    for (int l = 0; l < LANES; l++)
      r[l*DW +: DW] = DW'(abs_diff(a[l*DW +: DW], b[l*DW +: DW], sgn));
    return r;
  endfunction

  function automatic longint model_sad(int n, bit sgn);
    longint s = 0;
    for (int i = 0; i < n; i++)
      for (int l = 0; l < LANES; l++)
        s += abs_diff(va[i][l*DW +: DW], vb[i][l*DW +: DW], sgn);
    return s;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t r;
    for (int l = 0; l < LANES; l++)
      r[l*DW +: DW] = DW'({$urandom(), $urandom()});
    return r;
  endfunction

  task automatic fill_random(int n);
    for (int i = 0; i < n; i++) begin
      va[i] = rnd_vec();
      vb[i] = rnd_vec();
    end
  endtask

  // Plays one vector from va/vb and records what the DUT did; scenario tasks judge it.
  task automatic send_vector(input int cfg, input bit sgn, input int n, input int gap_pct, input int hold);
    obs_rdy_bad = 0;
    obs_early   = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        bus.in_valid   = 1'b0;
        bus.cfg_len    = LEN_W'($urandom());
        bus.cfg_signed = 1'($urandom_range(1));
        tick();
        if (bus.out_valid) obs_early++;
      end
      bus.in_valid = 1'b1;
      bus.in_a     = va[i];
      bus.in_b     = vb[i];
      if (i == 0) begin
        bus.cfg_len    = LEN_W'(cfg);
        bus.cfg_signed = sgn;
      end else begin
        bus.cfg_len    = LEN_W'($urandom());
        bus.cfg_signed = 1'($urandom_range(1));
      end
      if (!bus.in_ready) obs_rdy_bad++;
      tick();
      obs_diff[i] = bus.diff_out;
      obs_dv[i]   = bus.diff_valid;
      if (bus.out_valid) obs_early++;
    end
    bus.in_valid = 1'b0;
    obs_lat = 0;
    while (!bus.out_valid && obs_lat < 10) begin
      tick();
      obs_lat++;
    end
    obs_sad      = bus.sad_out;
    obs_unstable = 0;
    obs_hold_rdy = 0;
    obs_hold_acc = 0;
    for (int c = 0; c < hold; c++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = rnd_vec();
      tick();
      if (bus.sad_out !== obs_sad || !bus.out_valid) obs_unstable++;
      if (bus.in_ready) obs_hold_rdy++;
      if (bus.diff_valid) obs_hold_acc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    obs_rdy_after = bus.in_ready;
    obs_ov_after  = bus.out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); end
    checks++; if (bus.diff_out !== '0) begin errors++; $display("FAIL reset_diff_out got %0h exp 0", bus.diff_out); end
    checks++; if (bus.diff_valid !== 1'b0) begin errors++; $display("FAIL reset_diff_valid got %0b exp 0", bus.diff_valid); end
    checks++; if (bus.sad_out !== '0) begin errors++; $display("FAIL reset_sad_out got %0h exp 0", bus.sad_out); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_beat();
    va[0] = '0; vb[0] = '0;
    va[0][DW-1:0] = DW'(5);
    vb[0][DW-1:0] = DW'(9);
    send_vector(1, 1'b0, 1, 0, 0);
    checks++; if (obs_diff[0] !== model_diff(va[0], vb[0], 1'b0)) begin errors++; $display("FAIL single_diff got %0h exp %0h", obs_diff[0], model_diff(va[0], vb[0], 1'b0)); end
    checks++; if (obs_dv[0] !== 1'b1) begin errors++; $display("FAIL single_diff_valid got %0b exp 1", obs_dv[0]); end
    checks++; if (obs_sad !== ACC_W'(4)) begin errors++; $display("FAIL single_sad got %0d exp 4", obs_sad); end
    checks++; if (obs_lat !== 1) begin errors++; $display("FAIL single_latency got %0d exp 1", obs_lat); end
    checks++; if (obs_rdy_after !== 1'b1 || obs_ov_after !== 1'b0) begin errors++; $display("FAIL single_release got rdy=%0b ov=%0b exp rdy=1 ov=0", obs_rdy_after, obs_ov_after); end
  endtask

  task automatic test_extremes();
    logic [DW-1:0] all_ones;
    all_ones = '1;
    va[0] = '0; vb[0] = '0;
    va[0][DW-1:0] = {1'b1, {(DW-1){1'b0}}};
    vb[0][DW-1:0] = {1'b0, {(DW-1){1'b1}}};
    send_vector(1, 1'b1, 1, 0, 0);
    checks++; if (obs_diff[0][DW-1:0] !== all_ones) begin errors++; $display("FAIL signed_extreme_diff got %0h exp %0h", obs_diff[0][DW-1:0], all_ones); end
    checks++; if (obs_sad !== ACC_W'(model_sad(1, 1'b1))) begin errors++; $display("FAIL signed_extreme_sad got %0h exp %0h", obs_sad, model_sad(1, 1'b1)); end
    va[0] = '0; vb[0] = '0;
    vb[0][DW-1:0] = all_ones;
    send_vector(1, 1'b0, 1, 0, 0);
    checks++; if (obs_diff[0][DW-1:0] !== all_ones) begin errors++; $display("FAIL unsigned_extreme_diff got %0h exp %0h", obs_diff[0][DW-1:0], all_ones); end
    checks++; if (obs_sad !== ACC_W'(all_ones)) begin errors++; $display("FAIL unsigned_extreme_sad got %0h exp %0h", obs_sad, all_ones); end
  endtask

  task automatic test_gapped();
    logic [DW-1:0] b;
    for (int i = 0; i < 3; i++)
      for (int l = 0; l < LANES; l++) begin
        b = DW'($urandom_range(32'hFFFF_FFF0, 10));
        vb[i][l*DW +: DW] = b;
        va[i][l*DW +: DW] = ($urandom_range(1) == 1) ? b + DW'(10) : b - DW'(10);
      end
    send_vector(3, 1'b0, 3, 40, 0);
    checks++; if (obs_sad !== ACC_W'(120)) begin errors++; $display("FAIL gapped_sad got %0d exp 120", obs_sad); end
    checks++; if (obs_rdy_bad !== 0) begin errors++; $display("FAIL gapped_in_ready_low got %0d exp 0", obs_rdy_bad); end
    checks++; if (obs_early !== 0) begin errors++; $display("FAIL gapped_early_out got %0d exp 0", obs_early); end
    checks++; if (obs_lat !== 1) begin errors++; $display("FAIL gapped_latency got %0d exp 1", obs_lat); end
  endtask

  task automatic test_backpressure();
    bit sgn;
    sgn = 1'($urandom_range(1));
    fill_random(5);
    send_vector(5, sgn, 5, 0, 5);
    checks++; if (obs_sad !== ACC_W'(model_sad(5, sgn))) begin errors++; $display("FAIL bp_sad got %0h exp %0h", obs_sad, model_sad(5, sgn)); end
    checks++; if (obs_unstable !== 0) begin errors++; $display("FAIL bp_hold_stable got %0d exp 0", obs_unstable); end
    checks++; if (obs_hold_rdy !== 0) begin errors++; $display("FAIL bp_in_ready_during_hold got %0d exp 0", obs_hold_rdy); end
    checks++; if (obs_hold_acc !== 0) begin errors++; $display("FAIL bp_beats_taken_in_hold got %0d exp 0", obs_hold_acc); end
    checks++; if (obs_rdy_after !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after got %0b exp 1", obs_rdy_after); end
    sgn = 1'($urandom_range(1));
    fill_random(3);
    send_vector(3, sgn, 3, 0, 0);
    checks++; if (obs_sad !== ACC_W'(model_sad(3, sgn))) begin errors++; $display("FAIL bp_next_sad got %0h exp %0h", obs_sad, model_sad(3, sgn)); end
  endtask

  task automatic test_len_clamp();
    longint big;
    fill_random(1);
    send_vector(0, 1'b0, 1, 0, 0);
    checks++; if (obs_sad !== ACC_W'(model_sad(1, 1'b0))) begin errors++; $display("FAIL len0_sad got %0h exp %0h", obs_sad, model_sad(1, 1'b0)); end
    checks++; if (obs_lat !== 1) begin errors++; $display("FAIL len0_latency got %0d exp 1", obs_lat); end
    for (int i = 0; i < MAX_LEN; i++) begin
      va[i] = '1;
      vb[i] = '0;
    end
    big = 64'd256 * 64'h1_FFFF_FFFF;
    send_vector(100, 1'b0, MAX_LEN, 0, 0);
    checks++; if (obs_early !== 0 || obs_rdy_bad !== 0) begin errors++; $display("FAIL clamp_early got early=%0d rdy_bad=%0d exp 0 0", obs_early, obs_rdy_bad); end
    checks++; if (obs_lat !== 1) begin errors++; $display("FAIL clamp_latency got %0d exp 1", obs_lat); end
    checks++; if (obs_sad !== ACC_W'(big)) begin errors++; $display("FAIL clamp_max_sad got %0h exp %0h", obs_sad, big); end
  endtask

  task automatic test_reset_mid();
    fill_random(2);
    bus.cfg_len    = LEN_W'(4);
    bus.cfg_signed = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = va[i];
      bus.in_b     = vb[i];
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (bus.diff_out !== '0 || bus.diff_valid !== 1'b0) begin errors++; $display("FAIL midrst_diff got %0h/%0b exp 0/0", bus.diff_out, bus.diff_valid); end
    checks++; if (bus.sad_out !== '0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out got %0h/%0b exp 0/0", bus.sad_out, bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %0b exp 1", bus.in_ready); end
    rst_n = 1'b1;
    tick();
    fill_random(2);
    send_vector(2, 1'b1, 2, 0, 0);
    checks++; if (obs_lat !== 1) begin errors++; $display("FAIL midrst_next_latency got %0d exp 1", obs_lat); end
    checks++; if (obs_sad !== ACC_W'(model_sad(2, 1'b1))) begin errors++; $display("FAIL midrst_next_sad got %0h exp %0h", obs_sad, model_sad(2, 1'b1)); end
  endtask

  task automatic test_random();
    int n;
    bit sgn;
    for (int v = 0; v < 20; v++) begin
      n   = int'($urandom_range(8, 1));
      sgn = 1'($urandom_range(1));
      fill_random(n);
      send_vector(n, sgn, n, int'($urandom_range(30)), int'($urandom_range(3)));
      for (int i = 0; i < n; i++) begin
        checks++; if (obs_dv[i] !== 1'b1 || obs_diff[i] !== model_diff(va[i], vb[i], sgn)) begin errors++; $display("FAIL rand_diff v%0d b%0d got %0h dv=%0b exp %0h", v, i, obs_diff[i], obs_dv[i], model_diff(va[i], vb[i], sgn)); end
      end
      checks++; if (obs_sad !== ACC_W'(model_sad(n, sgn))) begin errors++; $display("FAIL rand_sad v%0d got %0h exp %0h", v, obs_sad, model_sad(n, sgn)); end
      checks++; if (obs_lat !== 1 || obs_early !== 0) begin errors++; $display("FAIL rand_timing v%0d got lat=%0d early=%0d exp 1 0", v, obs_lat, obs_early); end
      checks++; if (obs_rdy_after !== 1'b1) begin errors++; $display("FAIL rand_release v%0d got %0b exp 1", v, obs_rdy_after); end
    end
  endtask

  initial begin
    bus.cfg_len    = '0;
    bus.cfg_signed = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_single_beat();
    test_extremes();
    test_gapped();
    test_backpressure();
    test_len_clamp();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
